memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/y86_pkg.sv | 31 +++
 rtl/memory_access.sv | 188 ++++++++++++++++++
 tb/tb_memory_access.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status encodings and the
// memory-stage FSM state type.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status encodings
    localparam logic [1:0] AOK = 2'b00;
    localparam logic [1:0] ADR = 2'b10;
    localparam logic [1:0] INS = 2'b11;

    // Memory-stage FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } mem_state_e;

endpackage

// File: rtl/memory_access.sv
// Y86-64 memory stage: accepts one instruction from execute, performs at most
// one quadword data-memory access, and holds the result for write_back.
// Optional build macro MEM_TIMEOUT_EN abandons requests that are never acked.
module memory_access
    import y86_pkg::*;
#(
    parameter logic [63:0] DMEM_LIMIT     = 64'h1000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic        instr_valid_i,
    input  logic        imem_error_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  icode_o,
    output logic [63:0] valE_o,
    output logic [63:0] valM_o,
    output logic        instr_valid_o,
    output logic        imem_error_o,
    output logic        dmem_error_o
);

    // Legal when the whole quadword lies below the limit; the 65-bit sum
    // makes a wrap past 2^64 compare as illegal.
    function automatic logic addr_legal(input logic [63:0] addr);
        logic [64:0] w_end;
        w_end = {1'b0, addr} + 65'd8;
        return w_end <= {1'b0, DMEM_LIMIT};
    endfunction

    mem_state_e  r_state;
    mem_state_e  w_state_next;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_tmo_expire;

    logic        w_is_read;
    logic        w_is_write;
    logic        w_attempt;
    logic        w_go_req;
    logic        w_addr_err;
    logic [63:0] w_addr;

    logic [3:0]  r_icode;
    logic [63:0] r_valE;
    logic [63:0] r_valM;
    logic        r_instr_valid;
    logic        r_imem_error;
    logic        r_dmem_error;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    // Classify the presented instruction and check its access address.
    always_comb begin
        w_is_read  = (icode_i == IMRMOVQ) || (icode_i == IRET) || (icode_i == IPOPQ);
        w_is_write = (icode_i == IRMMOVQ) || (icode_i == ICALL) || (icode_i == IPUSHQ);
        w_addr     = ((icode_i == IRET) || (icode_i == IPOPQ)) ? valA_i : valE_i;
        w_attempt  = (w_is_read || w_is_write) && instr_valid_i && !imem_error_i;
        w_go_req   = w_attempt && addr_legal(w_addr);
        w_addr_err = w_attempt && !addr_legal(w_addr);
    end

    // Next state and handshake outputs; acceptance overrides the DONE->IDLE exit.
    always_comb begin
        w_in_ready   = 1'b0;
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
            end
            StReq: begin
                if (dmem_ack_i || w_tmo_expire) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_in_ready = out_ready_i;
                if (out_ready_i) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        w_accept = in_valid_i && w_in_ready;
        if (w_accept) begin
            w_state_next = w_go_req ? StReq : StDone;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the instruction on acceptance; capture read data or a timeout in REQ.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_icode       <= 4'd0;
            r_valE        <= 64'd0;
            r_valM        <= 64'd0;
            r_instr_valid <= 1'b0;
            r_imem_error  <= 1'b0;
            r_dmem_error  <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= 64'd0;
            r_wdata       <= 64'd0;
        end else if (w_accept) begin
            r_icode       <= icode_i;
            r_valE        <= valE_i;
            r_valM        <= 64'd0;
            r_instr_valid <= instr_valid_i;
            r_imem_error  <= imem_error_i;
            r_dmem_error  <= w_addr_err;
            r_we          <= w_is_write;
            r_addr        <= w_addr;
            r_wdata       <= valA_i;
        end else if (r_state == StReq) begin
            if (dmem_ack_i) begin
                // Only reads and writes reach REQ, so !r_we means read.
                if (!r_we) begin
                    r_valM <= dmem_rdata_i;
                end
            end else if (w_tmo_expire) begin
                r_dmem_error <= 1'b1;
                r_valM       <= 64'd0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmoW-1:0] r_tmo_cnt;

    // Expire on the last allowed REQ cycle when that cycle brings no ack.
    assign w_tmo_expire = (r_state == StReq) && !dmem_ack_i &&
                          (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));

    // Count REQ cycles; restart for every accepted instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StReq) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo_expire = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    assign in_ready_o    = w_in_ready;
    assign dmem_req_o    = (r_state == StReq);
    assign dmem_we_o     = r_we;
    assign dmem_addr_o   = r_addr;
    assign dmem_wdata_o  = r_wdata;
    assign out_valid_o   = (r_state == StDone);
    assign icode_o       = r_icode;
    assign valE_o        = r_valE;
    assign valM_o        = r_valM;
    assign instr_valid_o = r_instr_valid;
    assign imem_error_o  = r_imem_error;
    assign dmem_error_o  = r_dmem_error;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases, randomized
// transactions against a behavioural model, stall, reset and timeout checks.
module tb_memory_access;

    localparam logic [63:0] LIMIT = 64'h1000;
    localparam int unsigned TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  icode_i;
    logic [63:0] valE_i;
    logic [63:0] valA_i;
    logic        instr_valid_i;
    logic        imem_error_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  icode_o;
    logic [63:0] valE_o;
    logic [63:0] valM_o;
    logic        instr_valid_o;
    logic        imem_error_o;
    logic        dmem_error_o;

    int n_cmp  = 0;
    int n_fail = 0;

    memory_access #(
        .DMEM_LIMIT     (LIMIT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .icode_i       (icode_i),
        .valE_i        (valE_i),
        .valA_i        (valA_i),
        .instr_valid_i (instr_valid_i),
        .imem_error_i  (imem_error_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_ack_i    (dmem_ack_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .icode_o       (icode_o),
        .valE_o        (valE_o),
        .valM_o        (valM_o),
        .instr_valid_o (instr_valid_o),
        .imem_error_o  (imem_error_o),
        .dmem_error_o  (dmem_error_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] pick_addr();
        logic [63:0] a;
        case ($urandom_range(0, 4))
            0:       a = 64'($urandom_range(0, 511)) * 64'd8;
            1:       a = 64'hFF8;
            2:       a = 64'hFF9;
            3:       a = 64'hFFFF_FFFF_FFFF_FFFC;
            default: a = rand64();
        endcase
        return a;
    endfunction

    // Behavioural model: which icodes touch memory, where, and whether legal.
    task automatic run_txn(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                           input logic iv, input logic ie, input int ack_k,
                           input logic [63:0] rd, input int stall);
        logic        is_rd;
        logic        is_wr;
        logic [63:0] ea;
        logic        access;
        logic        legal;
        logic        exp_req;
        logic        exp_derr;
        logic [63:0] exp_valM;
        is_rd    = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        is_wr    = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        ea       = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
        access   = (is_rd || is_wr) && iv && !ie;
        legal    = (ea <= LIMIT - 64'd8) && (LIMIT >= 64'd8);
        exp_req  = access && legal;
        exp_derr = access && !legal;
        exp_valM = (exp_req && is_rd) ? rd : 64'd0;

        @(negedge clk);
        in_valid_i    = 1'b1;
        icode_i       = ic;
        valE_i        = ve;
        valA_i        = va;
        instr_valid_i = iv;
        imem_error_i  = ie;
        out_ready_i   = 1'b0;
        dmem_ack_i    = 1'b0;
        #1 chk1("accept_ready", in_ready_o, 1'b1);
        @(negedge clk);
        // Scramble inputs so outputs must come from latched values.
        in_valid_i    = 1'b0;
        icode_i       = 4'($urandom);
        valE_i        = rand64();
        valA_i        = rand64();
        instr_valid_i = 1'($urandom);
        imem_error_i  = 1'($urandom);
        if (exp_req) begin
            for (int k = 1; k <= ack_k; k++) begin
                chk1("req_high", dmem_req_o, 1'b1);
                chk64("req_addr", dmem_addr_o, ea);
                chk1("req_we", dmem_we_o, is_wr);
                if (is_wr) chk64("req_wdata", dmem_wdata_o, va);
                chk1("req_no_outvalid", out_valid_o, 1'b0);
                chk1("req_not_ready", in_ready_o, 1'b0);
                dmem_ack_i   = (k == ack_k);
                dmem_rdata_i = (k == ack_k) ? rd : rand64();
                @(negedge clk);
            end
            dmem_ack_i = 1'b0;
        end
        chk1("done_valid", out_valid_o, 1'b1);
        chk1("done_req_low", dmem_req_o, 1'b0);
        chk64("icode_o", {60'd0, icode_o}, {60'd0, ic});
        chk64("valE_o", valE_o, ve);
        chk64("valM_o", valM_o, exp_valM);
        chk1("instr_valid_o", instr_valid_o, iv);
        chk1("imem_error_o", imem_error_o, ie);
        chk1("dmem_error_o", dmem_error_o, exp_derr);
        // Stall with stray acks that must be ignored.
        for (int s = 0; s < stall; s++) begin
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = rand64();
            @(negedge clk);
            chk1("stall_valid", out_valid_o, 1'b1);
            chk1("stall_req_low", dmem_req_o, 1'b0);
            chk64("stall_valE", valE_o, ve);
            chk64("stall_valM", valM_o, exp_valM);
            chk1("stall_derr", dmem_error_o, exp_derr);
        end
        dmem_ack_i  = 1'b0;
        out_ready_i = 1'b1;
        #1 chk1("done_ready", in_ready_o, 1'b1);
        @(negedge clk);
        out_ready_i = 1'b0;
        chk1("idle_no_valid", out_valid_o, 1'b0);
        chk1("idle_ready", in_ready_o, 1'b1);
    endtask

    initial begin
        int cnt;
        rst_i         = 1'b1;
        in_valid_i    = 1'b0;
        icode_i       = 4'd0;
        valE_i        = 64'd0;
        valA_i        = 64'd0;
        instr_valid_i = 1'b1;
        imem_error_i  = 1'b0;
        dmem_ack_i    = 1'b0;
        dmem_rdata_i  = 64'd0;
        out_ready_i   = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_out_valid", out_valid_o, 1'b0);
        chk1("rst_req", dmem_req_o, 1'b0);
        chk1("rst_in_ready", in_ready_o, 1'b1);
        chk64("rst_valE", valE_o, 64'd0);
        chk64("rst_valM", valM_o, 64'd0);
        chk1("rst_derr", dmem_error_o, 1'b0);
        rst_i = 1'b0;

        // Directed cases.
        run_txn(4'h3, 64'h1234, 64'h0, 1'b1, 1'b0, 1, 64'h0, 0);
        run_txn(4'h5, 64'h100, 64'h0, 1'b1, 1'b0, 3, 64'hFEDC_BA09_8765_4321, 1);
        run_txn(4'hA, 64'hFF8, 64'hAB, 1'b1, 1'b0, 2, 64'h0, 0);
        run_txn(4'h4, 64'hFFC, 64'h55, 1'b1, 1'b0, 1, 64'h0, 0);
        run_txn(4'h5, 64'h100, 64'h0, 1'b0, 1'b0, 1, 64'h0, 0);
        run_txn(4'h5, 64'h100, 64'h0, 1'b1, 1'b1, 1, 64'h0, 0);
        run_txn(4'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1, 64'h0, 0);
        run_txn(4'hB, 64'hFFFF, 64'h800, 1'b1, 1'b0, 1, 64'h1122_3344_5566_7788, 0);
        run_txn(4'h8, 64'hFF9, 64'h42, 1'b1, 1'b0, 1, 64'h0, 0);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            run_txn(4'($urandom_range(0, 15)), pick_addr(), pick_addr(),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(1, 4)), rand64(), int'($urandom_range(0, 2)));
        end

        // Four-cycle stall, then back-to-back acceptance on the release cycle.
        @(negedge clk);
        in_valid_i    = 1'b1;
        icode_i       = 4'h3;
        valE_i        = 64'h55;
        instr_valid_i = 1'b1;
        imem_error_i  = 1'b0;
        out_ready_i   = 1'b0;
        @(negedge clk);
        in_valid_i = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk1("b2b_stall_valid", out_valid_o, 1'b1);
            chk64("b2b_stall_valE", valE_o, 64'h55);
            chk1("b2b_stall_ready", in_ready_o, 1'b0);
            @(negedge clk);
        end
        in_valid_i  = 1'b1;
        icode_i     = 4'h6;
        valE_i      = 64'h77;
        out_ready_i = 1'b1;
        #1 chk1("b2b_release_ready", in_ready_o, 1'b1);
        @(negedge clk);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk1("b2b_new_valid", out_valid_o, 1'b1);
        chk64("b2b_new_valE", valE_o, 64'h77);
        chk64("b2b_new_icode", {60'd0, icode_o}, 64'd6);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk1("b2b_idle", out_valid_o, 1'b0);

        // Reset in the middle of a request, with an ack that must be dropped.
        in_valid_i = 1'b1;
        icode_i    = 4'h5;
        valE_i     = 64'h200;
        @(negedge clk);
        in_valid_i = 1'b0;
        chk1("mid_req_1", dmem_req_o, 1'b1);
        @(negedge clk);
        chk1("mid_req_2", dmem_req_o, 1'b1);
        rst_i        = 1'b1;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        rst_i      = 1'b0;
        dmem_ack_i = 1'b0;
        chk1("mrst_req", dmem_req_o, 1'b0);
        chk1("mrst_valid", out_valid_o, 1'b0);
        chk1("mrst_ready", in_ready_o, 1'b1);
        chk64("mrst_valE", valE_o, 64'd0);
        chk64("mrst_valM", valM_o, 64'd0);
        chk64("mrst_addr", dmem_addr_o, 64'd0);
        chk64("mrst_icode", {60'd0, icode_o}, 64'd0);
        @(negedge clk);
        chk1("mrst_stay_idle", out_valid_o, 1'b0);

        // Request that is never acknowledged.
        in_valid_i = 1'b1;
        icode_i    = 4'h5;
        valE_i     = 64'h300;
        @(negedge clk);
        in_valid_i = 1'b0;
        cnt = 0;
`ifdef MEM_TIMEOUT_EN
        while (dmem_req_o && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk64("tmo_req_cycles", 64'(cnt), 64'(TMO));
        chk1("tmo_valid", out_valid_o, 1'b1);
        chk1("tmo_derr", dmem_error_o, 1'b1);
        chk64("tmo_valM", valM_o, 64'd0);
`else
        while (dmem_req_o && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk64("wait_req_cycles", 64'(cnt), 64'd20);
        chk1("wait_still_req", dmem_req_o, 1'b1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'h0BAD_F00D_1234_5678;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk1("wait_valid", out_valid_o, 1'b1);
        chk64("wait_valM", valM_o, 64'h0BAD_F00D_1234_5678);
        chk1("wait_derr", dmem_error_o, 1'b0);
`endif
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk1("final_idle", out_valid_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
